pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 8-bit-address processor.
- Drives the program counter's increment/load controls, handshakes with instruction memory, and latches the instruction register.
- Hands non-control-flow instructions to the datapath; resolves branches, jumps and halt itself.
- Sits between the PC register, instruction memory and the execute datapath.

Parameters:
- ADDR_W, 8, program counter / target address width
- INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1 -: 4], target = instr[ADDR_W-1:0]
- TIMEOUT_CYC, 15, max cycles waiting for mem_ack (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; starts/continues sequencing from IDLE
- pc_value  in  ADDR_W  current PC register value
- pc_inc  out  1  one-cycle pulse: PC <= PC+1
- pc_load  out  1  one-cycle pulse: PC <= pc_target
- pc_target  out  ADDR_W  load value, valid while pc_load=1
- mem_req  out  1  instruction read request, held until ack
- mem_addr  out  ADDR_W  read address (= pc_value captured at request)
- mem_ack  in  1  read complete; mem_rdata valid same cycle
- mem_rdata  in  INSTR_W  instruction word
- ir  out  INSTR_W  instruction register
- exec_start  out  1  one-cycle pulse to datapath
- exec_done  in  1  datapath completion pulse
- zero_flag  in  1  datapath zero flag, sampled in DECODE
- halted  out  1  high in HALT
- fault  out  1  sticky fetch-timeout flag (optional feature only; else tied 0)

Behaviour:
- Reset (reset=0, async): state=IDLE; ir=0; mem_addr=0; all pulse outputs, mem_req, halted, fault = 0.
- Opcodes: 4'hF HALT, 4'hE JMP, 4'hD BZ (branch if zero_flag), 4'h0 NOP; all others EXEC.
- State machine:
  - IDLE: if run=1, go to FETCH next cycle.
  - FETCH: assert mem_req, capture mem_addr=pc_value; go to WAIT.
  - WAIT: hold mem_req and mem_addr. On mem_ack: ir<=mem_rdata, drop mem_req, pulse pc_inc in the same cycle; go to DECODE.
  - DECODE:
    - HALT: go to HALT.
    - JMP, or BZ with zero_flag=1: pulse pc_load with pc_target=ir[ADDR_W-1:0]; go to FETCH.
    - BZ not taken, or NOP: go to FETCH.
    - EXEC: pulse exec_start; go to EXECUTE.
  - EXECUTE: wait for exec_done, then go to FETCH. If exec_done=1 in the first EXECUTE cycle, proceed normally.
  - HALT: halted=1. Exit only via reset.
- run=0 is sampled only in FETCH: return to IDLE without asserting mem_req. An in-flight WAIT/EXECUTE always completes.
- Fetch latency: mem_req on the cycle after entering FETCH. Minimum instruction period = 3 cycles (FETCH, WAIT with ack, DECODE) for NOP/branch.
- pc_inc and pc_load are never asserted in the same cycle. pc_inc wraps naturally at the PC (8'hFF -> 8'h00). Jump target 8'hFF is legal.
- mem_ack outside WAIT is ignored.
- Async reset mid-WAIT drops mem_req immediately. Memory must tolerate an abandoned request.

Optional Feature:
- Macro: PC_FETCH_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If TIMEOUT_CYC cycles pass without mem_ack:
  - fault<=1 (sticky until reset);
  - mem_req drops;
  - state goes to HALT.
  - Counter clears on entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; fault is constant 0.

Decomposition:
- Shared package proc_pkg holds:
  - opcode localparams (OP_NOP, OP_BZ, OP_JMP, OP_HALT);
  - state encoding constants;
  - ADDR_W/INSTR_W defaults.
- One natural sub-module: pc_opcode_decode.
  - Combinational: ir + zero_flag -> is_halt, take_branch, is_exec.
- The FSM stays in the top module.

Test Plan:
- Reset then run=1, NOP at addr 0, mem_ack after 2 WAIT cycles -> mem_addr=0, ir=16'h0000, one pc_inc pulse, next mem_req with mem_addr=1.
- JMP 0x40 (16'hE040) at addr 5 -> pc_inc in WAIT, pc_load with pc_target=8'h40 in DECODE, next mem_addr=8'h40.
- BZ 0x20 (16'hD020) twice:
  - zero_flag=0 -> no pc_load, next fetch at PC+1;
  - zero_flag=1 -> pc_load with 8'h20.
- EXEC opcode 16'h1234 -> exec_start pulses once, FSM holds 4 cycles until exec_done, then FETCH; no extra pc_inc.
- HALT 16'hF000 -> halted=1, no further mem_req with run=1 for 20 cycles; reset low mid-WAIT on a later run -> mem_req=0 and halted=0 immediately (asynchronous).
- With PC_FETCH_TIMEOUT_EN and TIMEOUT_CYC=15, never ack -> fault=1 and halted=1 after 15 WAIT cycles, mem_req=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the PC fetch sequencer: opcode values, FSM state
// encodings and default bus widths.
package proc_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int OPCODE_W    = 4;

  // Opcodes the sequencer resolves itself; every other value goes to the datapath.
  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_BZ   = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  // Sequencer states (plain constants so older tools can reuse the encoding).
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_DECODE  = 3'd3;
  localparam logic [2:0] ST_EXECUTE = 3'd4;
  localparam logic [2:0] ST_HALT    = 3'd5;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory read bus between the fetch sequencer (master) and the
// instruction memory (slave). The request is held until the ack, and the read
// data is valid in the cycle the ack is high.
interface pc_fetch_sequencer_if
  import proc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/pc_opcode_decode.sv
// Combinational opcode classification for the fetch sequencer. Produces
// exactly one of: halt, taken branch, datapath instruction, or fall-through
// (NOP / untaken BZ, when all three outputs are low).
module pc_opcode_decode
  import proc_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  output logic                is_halt,
  output logic                take_branch,
  output logic                is_exec
);

  // Classify the opcode; BZ only becomes a taken branch when zero_flag is set.
  always_comb begin
    is_halt     = 1'b0;
    take_branch = 1'b0;
    is_exec     = 1'b0;
    unique case (opcode)
      OP_HALT: is_halt     = 1'b1;
      OP_JMP:  take_branch = 1'b1;
      OP_BZ:   take_branch = zero_flag;
      OP_NOP:  ;
      default: is_exec     = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/execute controller for the 8-bit-address processor.
// Fetches an instruction from instruction memory, increments the PC in the
// same cycle the read completes, then resolves HALT/JMP/BZ/NOP locally or
// hands the instruction to the datapath and waits for its completion.
//
// Optional build macro PC_FETCH_TIMEOUT_EN: adds a fetch watchdog. If no
// mem_ack arrives within TIMEOUT_CYC cycles of WAIT, the request is dropped,
// the sticky fault flag is raised and the sequencer halts. Without the macro
// WAIT waits indefinitely and fault is tied low.
module pc_fetch_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
`ifdef PC_FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    pc_value,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic [ADDR_W-1:0]    pc_target,
  pc_fetch_sequencer_if.master bus,
  output logic [INSTR_W-1:0]   ir,
  output logic                 exec_start,
  input  logic                 exec_done,
  input  logic                 zero_flag,
  output logic                 halted,
  output logic                 fault
);

  logic [2:0]          state;
  logic [OPCODE_W-1:0] opcode;
  logic                is_halt;
  logic                take_branch;
  logic                is_exec;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign opcode = ir[INSTR_W-1 -: OPCODE_W];

  pc_opcode_decode u_decode (
    .opcode      (opcode),
    .zero_flag   (zero_flag),
    .is_halt     (is_halt),
    .take_branch (take_branch),
    .is_exec     (is_exec)
  );

  // PC increment accompanies the accepted read; branch load happens only in
  // DECODE, so the two PC controls can never coincide.
  assign pc_inc     = (state == ST_WAIT) && bus.mem_ack;
  assign pc_load    = (state == ST_DECODE) && take_branch;
  assign pc_target  = ir[ADDR_W-1:0];
  assign exec_start = (state == ST_DECODE) && is_exec;
  assign halted     = (state == ST_HALT);

  // Sequencer state, memory request/address, instruction register and watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ir           <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
`ifdef PC_FETCH_TIMEOUT_EN
      wait_cnt     <= '0;
      fault        <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          // run is only honoured here so an issued fetch always completes.
          if (!run) begin
            state <= ST_IDLE;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= pc_value;
            state        <= ST_WAIT;
`ifdef PC_FETCH_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            ir          <= bus.mem_rdata;
            bus.mem_req <= 1'b0;
            state       <= ST_DECODE;
          end
`ifdef PC_FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            bus.mem_req <= 1'b0;
            fault       <= 1'b1;
            state       <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_DECODE: begin
          if (is_halt)      state <= ST_HALT;
          else if (is_exec) state <= ST_EXECUTE;
          else              state <= ST_FETCH;
        end
        ST_EXECUTE: begin
          if (exec_done) state <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state       <= ST_IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef PC_FETCH_TIMEOUT_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed programs in a bench-side
// instruction memory, expected events queued by the stimulus and popped by a
// monitor whenever the DUT shows a request, PC pulse, exec start or halt.
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;
  import proc_pkg::*;

  typedef enum int {EV_REQ = 0, EV_INC = 1, EV_LOAD = 2, EV_EXEC = 3, EV_HALT = 4} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] val;
    int          gap;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  pc;
  logic        pc_inc;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic [15:0] ir;
  logic        exec_start;
  logic        exec_done;
  logic        zero_flag;
  logic        halted;
  logic        fault;

  logic        pc_set;
  logic [7:0]  pc_set_val;
  logic [15:0] imem [256];
  int          ack_delay;
  logic        hold_en;
  logic [7:0]  hold_addr;
  logic        spurious_ack;

  ev_t         exp_q[$];
  int          n_checks;
  int          n_fail;
  int          cyc;
  int          last_cyc;
  int          ev_idx;
  logic        ir_pending;
  logic [15:0] ir_exp;

  pc_fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  pc_fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .pc_value   (pc),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .bus        (bus),
    .ir         (ir),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .zero_flag  (zero_flag),
    .halted     (halted),
    .fault      (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-side PC register driven by the sequencer's increment/load pulses.
  always_ff @(posedge clk) begin
    if (pc_set)       pc <= pc_set_val;
    else if (pc_inc)  pc <= pc + 8'd1;
    else if (pc_load) pc <= pc_target;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [15:0] v, input int g);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  task automatic handle(input ev_kind_t k, input logic [15:0] act);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: actual kind %0d value %0h, required no event", k, act);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("ev%0d_kind", ev_idx), k, e.kind);
      if (k == EV_REQ || k == EV_LOAD || k == EV_EXEC)
        check($sformatf("ev%0d_value", ev_idx), act, e.val);
      if (e.gap >= 0)
        check($sformatf("ev%0d_gap", ev_idx), cyc - last_cyc, e.gap);
      if (e.kind == EV_INC) begin
        ir_pending = 1'b1;
        ir_exp     = e.val;
      end
      ev_idx++;
    end
    last_cyc = cyc;
  endtask

  // Instruction memory and datapath responder, driven on the falling edge.
  initial begin
    int   wcnt;
    int   exec_k;
    logic exec_busy;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    exec_done     = 1'b0;
    zero_flag     = 1'b0;
    wcnt          = 0;
    exec_k        = 0;
    exec_busy     = 1'b0;
    forever begin
      @(negedge clk);
      zero_flag = (bus.mem_addr == 8'h41);
      if (bus.mem_req) begin
        if (hold_en && bus.mem_addr == hold_addr) begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = '0;
        end else if (wcnt == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = imem[bus.mem_addr];
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt          = 0;
        bus.mem_ack   = spurious_ack;
        bus.mem_rdata = 16'hBEEF;
      end
      if (exec_busy) begin
        exec_k++;
        exec_done = (exec_k == 4);
        if (exec_k == 4) exec_busy = 1'b0;
      end else begin
        exec_done = 1'b0;
      end
      if (exec_start) begin
        exec_busy = 1'b1;
        exec_k    = 0;
      end
    end
  end

  // Monitor: pops one expectation per observed DUT event.
  initial begin
    logic prev_req;
    logic prev_halt;
    prev_req   = 1'b0;
    prev_halt  = 1'b0;
    cyc        = 0;
    last_cyc   = 0;
    ev_idx     = 0;
    ir_pending = 1'b0;
    ir_exp     = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (ir_pending) begin
        check($sformatf("ir_after_ev%0d", ev_idx), ir, ir_exp);
        ir_pending = 1'b0;
      end
      if (pc_inc || pc_load) check("pc_inc_load_exclusive", pc_inc & pc_load, 1'b0);
      if (bus.mem_req && !prev_req) handle(EV_REQ, {8'h00, bus.mem_addr});
      if (pc_inc) handle(EV_INC, 16'h0000);
      if (pc_load) handle(EV_LOAD, {8'h00, pc_target});
      if (exec_start) handle(EV_EXEC, ir);
      if (halted && !prev_halt) handle(EV_HALT, 16'h0000);
      prev_req  = bus.mem_req;
      prev_halt = halted;
    end
  end

  task automatic wait_drain(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  // Directed stimulus.
  initial begin
    logic found;
    int   req_cycles;
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    run          = 1'b0;
    pc_set       = 1'b1;
    pc_set_val   = 8'h00;
    ack_delay    = 2;
    hold_en      = 1'b0;
    hold_addr    = 8'h00;
    spurious_ack = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h01] = 16'hE005;
    imem[8'h05] = 16'hE040;
    imem[8'h40] = 16'hD020;
    imem[8'h41] = 16'hD020;
    imem[8'h20] = 16'h1234;
    imem[8'h21] = 16'hF000;
    imem[8'h30] = 16'hE0FF;

    repeat (2) @(negedge clk);
    #3;
    check("rst_ir", ir, 16'h0000);
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_pc_inc", pc_inc, 1'b0);
    check("rst_pc_load", pc_load, 1'b0);
    check("rst_exec_start", exec_start, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);

    // Program run: NOP, JMP chain, BZ untaken/taken, EXEC, HALT.
    @(negedge clk);
    reset  = 1'b1;
    pc_set = 1'b0;
    push(EV_REQ,  16'h0000, -1);
    push(EV_INC,  16'h0000,  2);
    push(EV_REQ,  16'h0001,  3);
    push(EV_INC,  16'hE005,  2);
    push(EV_LOAD, 16'h0005,  1);
    push(EV_REQ,  16'h0005,  2);
    push(EV_INC,  16'hE040,  2);
    push(EV_LOAD, 16'h0040,  1);
    push(EV_REQ,  16'h0040,  2);
    push(EV_INC,  16'hD020,  2);
    push(EV_REQ,  16'h0041,  3);
    push(EV_INC,  16'hD020,  2);
    push(EV_LOAD, 16'h0020,  1);
    push(EV_REQ,  16'h0020,  2);
    push(EV_INC,  16'h1234,  2);
    push(EV_EXEC, 16'h1234,  1);
    push(EV_REQ,  16'h0021,  6);
    push(EV_INC,  16'hF000,  2);
    push(EV_HALT, 16'h0000,  2);
    run = 1'b1;
    wait_drain(300, "phase1_drain");

    req_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      #3;
      if (bus.mem_req) req_cycles++;
    end
    check("halt_holds", halted, 1'b1);
    check("halt_no_req_cycles", req_cycles, 0);

    // Reset out of HALT; spurious ack in IDLE; JMP to 0xFF and PC wrap.
    @(negedge clk);
    #3;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    check("halt_exit_async_halted", halted, 1'b0);
    check("halt_exit_async_req", bus.mem_req, 1'b0);
    pc_set     = 1'b1;
    pc_set_val = 8'h30;
    ack_delay  = 0;
    hold_en    = 1'b1;
    hold_addr  = 8'h00;
    repeat (2) @(negedge clk);
    reset        = 1'b1;
    pc_set       = 1'b0;
    spurious_ack = 1'b1;
    repeat (3) @(negedge clk);
    spurious_ack = 1'b0;
    #3;
    check("spurious_ack_ir", ir, 16'h0000);
    check("spurious_ack_req", bus.mem_req, 1'b0);
    check("spurious_ack_pc", pc, 8'h30);
    push(EV_REQ,  16'h0030, -1);
    push(EV_INC,  16'hE0FF,  0);
    push(EV_LOAD, 16'h00FF,  1);
    push(EV_REQ,  16'h00FF,  2);
    push(EV_INC,  16'h0000,  0);
    push(EV_REQ,  16'h0000,  3);
    run   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      #3;
      if (bus.mem_req && bus.mem_addr == 8'h00) found = 1'b1;
    end
    check("wrap_reach_wait_00", found, 1'b1);
    check("wrap_events_left", exp_q.size(), 0);

    // Asynchronous reset in the middle of WAIT.
    repeat (3) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midwait_rst_req", bus.mem_req, 1'b0);
    check("midwait_rst_halted", halted, 1'b0);
    check("midwait_rst_fault", fault, 1'b0);
    check("midwait_rst_pc_inc", pc_inc, 1'b0);

    // Never-acked fetch: watchdog halts, or the request is held forever.
    pc_set     = 1'b1;
    pc_set_val = 8'h50;
    hold_addr  = 8'h50;
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    pc_set = 1'b0;
    push(EV_REQ, 16'h0050, -1);
`ifdef PC_FETCH_TIMEOUT_EN
    push(EV_HALT, 16'h0000, 15);
`endif
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #3;
      if (bus.mem_req) found = 1'b1;
    end
    check("noack_req_seen", found, 1'b1);
    repeat (14) @(negedge clk);
    #3;
    check("noack_wait15_req", bus.mem_req, 1'b1);
    check("noack_wait15_fault", fault, 1'b0);
    check("noack_wait15_halted", halted, 1'b0);
    @(negedge clk);
    #3;
`ifdef PC_FETCH_TIMEOUT_EN
    check("timeout_fault", fault, 1'b1);
    check("timeout_halted", halted, 1'b1);
    check("timeout_req", bus.mem_req, 1'b0);
`else
    check("noack_wait16_req", bus.mem_req, 1'b1);
    check("noack_wait16_fault", fault, 1'b0);
    check("noack_wait16_halted", halted, 1'b0);
    repeat (20) @(negedge clk);
    #3;
    check("noack_long_req", bus.mem_req, 1'b1);
    check("noack_long_fault", fault, 1'b0);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
